// File: rtl/vend_pkg.sv
// Shared types and constants for the vending transaction controller.
// The optional dispense timeout is enabled by defining DISP_TIMEOUT_EN.
package vend_pkg;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_DISP = 2'd1,
      S_WAIT = 2'd2,
      S_CHG  = 2'd3
   } state_t;

   localparam logic [1:0] CT_1  = 2'd0;
   localparam logic [1:0] CT_5  = 2'd1;
   localparam logic [1:0] CT_10 = 2'd2;

   localparam logic [3:0] CV_1  = 4'd1;
   localparam logic [3:0] CV_5  = 4'd5;
   localparam logic [3:0] CV_10 = 4'd10;

   localparam int PRICE_A_DEF    = 2;
   localparam int PRICE_B_DEF    = 6;
   localparam int STOCK_INIT_DEF = 8;
   localparam int PULSE_W_DEF    = 4;
   localparam int BAL_MAX_DEF    = 99;
   localparam int TMO_CYC        = 255;

   function automatic logic coin_ok(input logic [3:0] v);
      return (v == CV_1) || (v == CV_5) || (v == CV_10);
   endfunction

   // Greedy change selection: largest coin not exceeding the balance.
   function automatic logic [1:0] coin_type_of(input logic [7:0] bal);
      if (bal >= 8'(CV_10))     return CT_10;
      else if (bal >= 8'(CV_5)) return CT_5;
      else                      return CT_1;
   endfunction

   function automatic logic [7:0] coin_value_of(input logic [1:0] t);
      case (t)
         CT_10:   return 8'(CV_10);
         CT_5:    return 8'(CV_5);
         default: return 8'(CV_1);
      endcase
   endfunction

endpackage

// File: rtl/vend_pulse_timer.sv
// Loadable down-counter; zero flags expiry. Times the actuator pulse and,
// when DISP_TIMEOUT_EN is defined, the dispense-complete timeout.
module vend_pulse_timer #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         load,
   input  logic [W-1:0] load_val,
   input  logic         en,
   output logic         zero
);

   logic [W-1:0] cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                cnt <= '0;
      else if (load)             cnt <= load_val;
      else if (en && cnt != '0)  cnt <= cnt - 1'b1;
   end

   assign zero = (cnt == '0);

endmodule

// File: rtl/vend_dispatch.sv
// Vending transaction controller: credit, purchase/refund arbitration, dispense
// sequencing and coin-by-coin change. Optional feature macro: DISP_TIMEOUT_EN.
module vend_dispatch
   import vend_pkg::*;
#(
   parameter int PRICE_A    = PRICE_A_DEF,
   parameter int PRICE_B    = PRICE_B_DEF,
   parameter int STOCK_INIT = STOCK_INIT_DEF,
   parameter int PULSE_W    = PULSE_W_DEF,
   parameter int BAL_MAX    = BAL_MAX_DEF
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       coin_vld,
   input  logic [3:0] coin_val,
   input  logic       req_a,
   input  logic       req_b,
   input  logic       req_back,
   input  logic       refill,
   input  logic       act_done,
   input  logic       coin_rdy,
   output logic       put_a,
   output logic       put_b,
   output logic       coin_out_vld,
   output logic [1:0] coin_out_type,
   output logic       coin_rej,
   output logic       nack,
   output logic [7:0] balance,
   output logic       have_a,
   output logic       have_b,
   output logic       busy,
   output logic       err,
   output state_t     fsm_state
);

   state_t     state, state_n;
   logic [7:0] bal_n;
   logic [3:0] stock_a, stock_a_n, stock_b, stock_b_n;
   logic       sel_b, sel_b_n;
   logic       act_seen, act_seen_n;
   logic       coin_rej_n, nack_n;
   logic       tmr_load, tmr_en, tmr_zero;
   logic [7:0] tmr_val;
   logic [8:0] coin_sum;
   logic [7:0] chg_val;
`ifdef DISP_TIMEOUT_EN
   logic       err_q, err_n;
   logic [8:0] refund_sum;
`endif

   vend_pulse_timer #(.W(8)) u_timer (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (tmr_load),
      .load_val (tmr_val),
      .en       (tmr_en),
      .zero     (tmr_zero)
   );

   always_comb begin
      state_n    = state;
      bal_n      = balance;
      stock_a_n  = stock_a;
      stock_b_n  = stock_b;
      sel_b_n    = sel_b;
      act_seen_n = act_seen;
      coin_rej_n = 1'b0;
      nack_n     = 1'b0;
      tmr_load   = 1'b0;
      tmr_en     = 1'b0;
      tmr_val    = 8'(PULSE_W - 1);
      coin_sum   = 9'(balance) + 9'(coin_val);
      chg_val    = coin_value_of(coin_type_of(balance));
`ifdef DISP_TIMEOUT_EN
      err_n      = err_q;
      refund_sum = 9'(balance) + (sel_b ? 9'(PRICE_B) : 9'(PRICE_A));
`endif

      if (coin_vld) begin
         if (state == S_IDLE && coin_ok(coin_val) && coin_sum <= 9'(BAL_MAX))
            bal_n = coin_sum[7:0];
         else
            coin_rej_n = 1'b1;
      end

      case (state)
         S_IDLE: begin
            // Requests see the pre-coin balance; the price comes off bal_n so
            // a same-cycle coin is still credited.
            if (refill) begin
               stock_a_n = 4'(STOCK_INIT);
               stock_b_n = 4'(STOCK_INIT);
            end else if (req_back) begin
               if (balance == 8'd0) nack_n  = 1'b1;
               else                 state_n = S_CHG;
            end else if (req_b) begin
               if (balance >= 8'(PRICE_B) && stock_b != 4'd0) begin
                  bal_n      = bal_n - 8'(PRICE_B);
                  sel_b_n    = 1'b1;
                  act_seen_n = 1'b0;
                  tmr_load   = 1'b1;
                  state_n    = S_DISP;
               end else nack_n = 1'b1;
            end else if (req_a) begin
               if (balance >= 8'(PRICE_A) && stock_a != 4'd0) begin
                  bal_n      = bal_n - 8'(PRICE_A);
                  sel_b_n    = 1'b0;
                  act_seen_n = 1'b0;
                  tmr_load   = 1'b1;
                  state_n    = S_DISP;
               end else nack_n = 1'b1;
            end
         end
         S_DISP: begin
            tmr_en = 1'b1;
            if (act_done) act_seen_n = 1'b1;
            if (tmr_zero) begin
               state_n  = S_WAIT;
               tmr_load = 1'b1;
               tmr_val  = 8'(TMO_CYC - 1);
            end
         end
         S_WAIT: begin
            if (act_done || act_seen) begin
               if (sel_b) stock_b_n = stock_b - 4'd1;
               else       stock_a_n = stock_a - 4'd1;
               act_seen_n = 1'b0;
               state_n    = S_IDLE;
            end
`ifdef DISP_TIMEOUT_EN
            else begin
               tmr_en = 1'b1;
               if (tmr_zero) begin
                  bal_n   = (refund_sum > 9'(BAL_MAX)) ? 8'(BAL_MAX) : refund_sum[7:0];
                  err_n   = 1'b1;
                  state_n = S_IDLE;
               end
            end
`endif
         end
         S_CHG: begin
            // coin_out_vld/coin_out_type hold steady until the hopper raises
            // coin_rdy; a coin transfers on a cycle where both are high.
            if (coin_rdy) begin
               bal_n = balance - chg_val;
               if (bal_n == 8'd0) state_n = S_IDLE;
            end
         end
         default: state_n = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= S_IDLE;
         balance  <= 8'd0;
         stock_a  <= 4'(STOCK_INIT);
         stock_b  <= 4'(STOCK_INIT);
         sel_b    <= 1'b0;
         act_seen <= 1'b0;
         coin_rej <= 1'b0;
         nack     <= 1'b0;
      end else begin
         state    <= state_n;
         balance  <= bal_n;
         stock_a  <= stock_a_n;
         stock_b  <= stock_b_n;
         sel_b    <= sel_b_n;
         act_seen <= act_seen_n;
         coin_rej <= coin_rej_n;
         nack     <= nack_n;
      end
   end

`ifdef DISP_TIMEOUT_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) err_q <= 1'b0;
      else        err_q <= err_n;
   end
   assign err = err_q;
`else
   assign err = 1'b0;
`endif

   assign put_a         = (state == S_DISP) && !sel_b;
   assign put_b         = (state == S_DISP) && sel_b;
   assign coin_out_vld  = (state == S_CHG);
   assign coin_out_type = coin_type_of(balance);
   assign have_a        = (stock_a != 4'd0);
   assign have_b        = (stock_b != 4'd0);
   assign busy          = (state != S_IDLE);
   assign fsm_state     = state;

endmodule
